tlb_set_assoc: RTL

TLB_SET_ASSOC -- requirements
Module: tlb_set_assoc

---
 rtl/tlb_set_assoc.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/tlb_set_assoc.sv
// Set-associative TLB with bit-PLRU replacement and a one-set-per-cycle
// flush sweep.
//
// Ports:
//   clk, rstn        clock, asynchronous active-low reset
//   i_req_valid      request present; accepted when o_req_ready is high
//   o_req_ready      high in IDLE when no flush is being requested
//   i_req_write      1 = insert/update, 0 = lookup
//   i_req_vpn        VPN; low INDEXSIZE bits select the set, the rest is the tag
//   i_req_ppn        PPN to store on writes
//   i_flush          pulse that starts invalidating every set
//   o_rsp_valid      one-cycle response strobe, the cycle after acceptance
//   o_rsp_hit        tag matched a valid way
//   o_rsp_ppn        translated PPN (new PPN on writes, 0 on read miss)
//   o_flush_busy     sweep in progress
module tlb_set_assoc #(
    parameter int INDEXSIZE = 6,
    parameter int WAYS      = 4,
    parameter int VPNSIZE   = 16,
    parameter int PPNSIZE   = 12
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               i_req_valid,
    output logic               o_req_ready,
    input  logic               i_req_write,
    input  logic [VPNSIZE-1:0] i_req_vpn,
    input  logic [PPNSIZE-1:0] i_req_ppn,
    input  logic               i_flush,
    output logic               o_rsp_valid,
    output logic               o_rsp_hit,
    output logic [PPNSIZE-1:0] o_rsp_ppn,
    output logic               o_flush_busy
);

    localparam int SETS = 1 << INDEXSIZE;
    localparam int TAGW = VPNSIZE - INDEXSIZE;
    localparam int WAYW = $clog2(WAYS);

    typedef enum logic {
        IDLE,
        FLUSH
    } state_e;

    state_e               state_q, state_d;
    logic [INDEXSIZE-1:0] cnt_q, cnt_d;

    logic [TAGW-1:0]    tag_q [SETS][WAYS];
    logic [PPNSIZE-1:0] ppn_q [SETS][WAYS];

    logic [SETS-1:0][WAYS-1:0] valid_q;
    logic [SETS-1:0][WAYS-1:0] mru_q;

    logic               rsp_valid_q;
    logic               rsp_hit_q;
    logic [PPNSIZE-1:0] rsp_ppn_q;

    logic [INDEXSIZE-1:0] idx;
    logic [TAGW-1:0]      tag;
    logic                 accept;
    logic                 hit;
    logic [WAYW-1:0]      hit_way;
    logic [WAYW-1:0]      victim;
    logic                 found;
    logic [WAYW-1:0]      touch_way;
    logic [WAYS-1:0]      onehot;
    logic [WAYS-1:0]      mru_set;
    logic [WAYS-1:0]      mru_new;
    logic [PPNSIZE-1:0]   rsp_ppn_d;

    assign idx    = i_req_vpn[INDEXSIZE-1:0];
    assign tag    = i_req_vpn[VPNSIZE-1:INDEXSIZE];
    assign accept = i_req_valid && o_req_ready;

    assign o_req_ready  = rstn && (state_q == IDLE) && !i_flush;
    assign o_flush_busy = (state_q == FLUSH);
    assign o_rsp_valid  = rsp_valid_q;
    assign o_rsp_hit    = rsp_hit_q;
    assign o_rsp_ppn    = rsp_ppn_q;

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[idx][w] && tag_q[idx][w] == tag) begin
                hit     = 1'b1;
                hit_way = WAYW'(w);
            end
        end
    end

    // Victim: first invalid way, otherwise first way not recently used.
    always_comb begin
        found  = 1'b0;
        victim = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (!found && !valid_q[idx][w]) begin
                found  = 1'b1;
                victim = WAYW'(w);
            end
        end
        for (int w = 0; w < WAYS; w++) begin
            if (!found && !mru_q[idx][w]) begin
                found  = 1'b1;
                victim = WAYW'(w);
            end
        end
    end

    // Saturated MRU set collapses to just the touched way.
    always_comb begin
        touch_way         = hit ? hit_way : victim;
        onehot            = '0;
        onehot[touch_way] = 1'b1;
        mru_set           = mru_q[idx] | onehot;
        mru_new           = (&mru_set) ? onehot : mru_set;
        if (i_req_write) begin
            rsp_ppn_d = i_req_ppn;
        end else if (hit) begin
            rsp_ppn_d = ppn_q[idx][hit_way];
        end else begin
            rsp_ppn_d = '0;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (i_flush) begin
                    state_d = FLUSH;
                    cnt_d   = '0;
                end
            end
            FLUSH: begin
                cnt_d = cnt_q + INDEXSIZE'(1);
                if (&cnt_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            valid_q     <= '0;
            mru_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_hit_q   <= 1'b0;
            rsp_ppn_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= accept;
            if (accept) begin
                rsp_hit_q <= hit;
                rsp_ppn_q <= rsp_ppn_d;
            end
            if (state_q == FLUSH) begin
                valid_q[cnt_q] <= '0;
                mru_q[cnt_q]   <= '0;
            end else if (accept && (i_req_write || hit)) begin
                mru_q[idx] <= mru_new;
                if (i_req_write) begin
                    valid_q[idx][touch_way] <= 1'b1;
                end
            end
        end
    end

    // Tag/PPN payload is never reset; valid bits qualify it.
    always_ff @(posedge clk) begin
        if (accept && i_req_write) begin
            tag_q[idx][touch_way] <= tag;
            ppn_q[idx][touch_way] <= i_req_ppn;
        end
    end

endmodule
